sumdiff_decoder: RTL and testbench
==================================

Name: sumdiff_decoder

Overview:
Inverse of the team's registered select/add/subtract unit. It consumes a stream of 9-bit signed results, each tagged with the 2-bit select code that produced it (a, b, a+b, a-b). Once two distinct kinds have been received, it recovers the original 8-bit signed operands a and b and presents them on a valid/ready output. It sits on the checker/loopback path after the arithmetic unit, for self-test and operand reconstruction.

Parameters:
W, 8, operand width; input result width is W+1, internal solve width is W+2.

Ports:
clk  input  1  clock; all logic rising-edge.
rst  input  1  reset; asynchronous assert, active-high.
clear  input  1  synchronous flush; drops any partial capture and any pending output.
in_valid  input  1  input word present.
in_ready  output  1  decoder can accept a word.
in_sel  input  2  kind: 00 = a, 01 = b, 10 = a+b, 11 = a-b.
in_c  input  W+1  signed result value.
out_valid  output  1  recovered pair valid.
out_ready  input  1  consumer accepts pair.
out_a  output  W  signed recovered a.
out_b  output  W  signed recovered b.
out_err  output  1  pair inconsistent or out of range; valid only with out_valid.

Behaviour:
- Reset values: state EMPTY, out_valid 0, out_a 0, out_b 0, out_err 0, both capture slots cleared. in_ready = (state != OUT), so it reads 1 during reset.
- Input handshake: a word is accepted when in_valid && in_ready on a clock edge. in_c and in_sel are sampled only on acceptance.
- Output handshake: a transfer occurs when out_valid && out_ready. out_a, out_b and out_err are stable while out_valid=1 and out_ready=0.
- State EMPTY:
  - An accepted word is stored into slot0 as {kind, value}.
  - Next state is ONE.
- State ONE:
  - An accepted word of the same kind as slot0 overwrites slot0 (latest wins). State stays ONE.
  - An accepted word of a different kind is combined with slot0 by the solver. out_a, out_b and out_err are registered, out_valid=1 on the next edge, and state goes to OUT.
  - Latency: the completing word is accepted at edge N and out_valid is high after edge N (visible in cycle N+1).
- State OUT:
  - in_ready=0.
  - On an output transfer: out_valid goes to 0, the slots are cleared, and state returns to EMPTY.
  - No input word can be accepted in the same cycle as the output transfer.
- Solver arithmetic: all operands are sign-extended to W+2 bits; s = sum, d = diff.
  - {a, b}: direct.
  - {a, s}: b = s - a.
  - {a, d}: b = a - d.
  - {b, s}: a = s - b.
  - {b, d}: a = d + b.
  - {s, d}: a = (s + d) >>> 1 and b = (s - d) >>> 1. The operation is an arithmetic shift; the discarded LSB must be 0.
- out_err = 1 if any of the following holds:
  - a captured kind-a or kind-b value lies outside [-2^(W-1), 2^(W-1)-1];
  - a computed a or b lies outside that range;
  - the sum/diff pair has s + d odd.
- When out_err=1, out_a and out_b are driven to 0.
- clear has priority over everything except rst. On clear: state goes to EMPTY, out_valid goes to 0, and the slots are cleared, including when clear coincides with an input accept or an output transfer.
- rst asserted mid-operation forces all reset values immediately, without waiting for a clock edge.

Decomposition:
- Shared package sumdiff_pkg holds:
  - kind encodings KIND_A = 2'b00, KIND_B = 2'b01, KIND_SUM = 2'b10, KIND_DIFF = 2'b11 (these must match the select encoding of the arithmetic unit);
  - the state enum EMPTY/ONE/OUT.
- One combinational sub-module, sumdiff_solve. Inputs: two {kind, value} slots. Outputs: a, b, err. It contains all the width and range logic.
- The top level holds the FSM, the slots, the handshakes and the output registers.

Test Plan:
- Sum then diff: (sel 10, c = 5), then (sel 11, c = -9), out_ready = 1 → out_valid one cycle after the second accept, out_a = -2, out_b = 7, out_err = 0. Then in_ready returns to 1.
- Odd pair: (sel 10, c = 4), then (sel 11, c = 1) → out_err = 1, out_a = 0, out_b = 0.
- Overflow: (sel 00, c = 100), then (sel 10, c = -200) → b = -300 is out of range, so out_err = 1. Separately, (sel 01, c = 200) paired with (sel 00, c = 1) → out_err = 1.
- Duplicate kind and backpressure: (sel 00, c = 3), (sel 00, c = -4), then (sel 11, c = -10) with out_ready held 0 for 5 cycles:
  - out_a = -4, out_b = 6, and both are held stable;
  - in_ready stays 0 and in_valid words offered during the stall are not accepted;
  - the transfer occurs on the first cycle out_ready = 1.
- Boundary: (sel 00, c = -128) with (sel 01, c = 127) → out_a = -128, out_b = 127, out_err = 0. Also (sel 10, c = -256) with (sel 11, c = 0) → out_a = -128, out_b = -128.
- clear and rst:
  - clear in state ONE → the next pair starts fresh.
  - clear asserted together with out_valid and out_ready → state EMPTY and no double transfer.
  - rst asserted mid-ONE between clock edges → out_valid = 0 and in_ready = 1 immediately.

Source files
------------

// File: rtl/sumdiff_pkg.sv
// Shared encodings for the sum/diff decoder: select kinds (matching the arithmetic unit) and FSM states.
package sumdiff_pkg;

  localparam int unsigned SEL_W = 2;

  localparam logic [SEL_W-1:0] KIND_A    = 2'b00;
  localparam logic [SEL_W-1:0] KIND_B    = 2'b01;
  localparam logic [SEL_W-1:0] KIND_SUM  = 2'b10;
  localparam logic [SEL_W-1:0] KIND_DIFF = 2'b11;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    OUT   = 2'd2
  } state_t;

endpackage

// File: rtl/sumdiff_solve.sv
// Combinational solver: recovers (a, b) from two distinct {kind, value} captures and flags
// inconsistent or out-of-range results.
module sumdiff_solve #(
  parameter int unsigned W = 8
) (
  input  logic [1:0]          kind0,
  input  logic signed [W:0]   val0,
  input  logic [1:0]          kind1,
  input  logic signed [W:0]   val1,
  output logic signed [W-1:0] a,
  output logic signed [W-1:0] b,
  output logic                err
);
  import sumdiff_pkg::*;

  localparam int unsigned SW = W + 2;
  localparam int unsigned HW = SW - W + 1;

  logic signed [SW-1:0] x0, x1;
  logic signed [SW-1:0] va, vb, vs, vd;
  logic signed [SW-1:0] t_sum, t_dif;
  logic signed [SW-1:0] ra, rb;
  logic                 has_a, has_b, has_s, has_d;
  logic                 odd, bad_pair;

  // A value fits W signed bits when its top HW bits are all copies of the sign.
  function automatic logic fits(input logic signed [SW-1:0] x);
    return (x[SW-1:W-1] == {HW{1'b0}}) || (x[SW-1:W-1] == {HW{1'b1}});
  endfunction

  always_comb begin
    x0       = SW'(val0);
    x1       = SW'(val1);
    has_a    = (kind0 == KIND_A)    || (kind1 == KIND_A);
    has_b    = (kind0 == KIND_B)    || (kind1 == KIND_B);
    has_s    = (kind0 == KIND_SUM)  || (kind1 == KIND_SUM);
    has_d    = (kind0 == KIND_DIFF) || (kind1 == KIND_DIFF);
    va       = (kind0 == KIND_A)    ? x0 : x1;
    vb       = (kind0 == KIND_B)    ? x0 : x1;
    vs       = (kind0 == KIND_SUM)  ? x0 : x1;
    vd       = (kind0 == KIND_DIFF) ? x0 : x1;
    t_sum    = vs + vd;
    t_dif    = vs - vd;
    ra       = '0;
    rb       = '0;
    odd      = 1'b0;
    bad_pair = 1'b0;

    case ({has_a, has_b, has_s, has_d})
      4'b1100: begin ra = va;           rb = vb;           end
      4'b1010: begin ra = va;           rb = vs - va;      end
      4'b1001: begin ra = va;           rb = va - vd;      end
      4'b0110: begin ra = vs - vb;      rb = vb;           end
      4'b0101: begin ra = vd + vb;      rb = vb;           end
      4'b0011: begin
        ra  = t_sum >>> 1;
        rb  = t_dif >>> 1;
        odd = t_sum[0];
      end
      default: bad_pair = 1'b1;
    endcase

    err = bad_pair || odd || !fits(ra) || !fits(rb);
    a   = err ? '0 : ra[W-1:0];
    b   = err ? '0 : rb[W-1:0];
  end

endmodule

// File: rtl/sumdiff_decoder.sv
// Rebuilds (a, b) operands from a stream of tagged select/add/subtract results; one captured
// slot plus the live word feed the solver, and the result is held on a valid/ready output.
module sumdiff_decoder #(
  parameter int unsigned W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clear,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [1:0]          in_sel,
  input  logic signed [W:0]   in_c,
  output logic                out_valid,
  input  logic                out_ready,
  output logic signed [W-1:0] out_a,
  output logic signed [W-1:0] out_b,
  output logic                out_err
);
  import sumdiff_pkg::*;

  state_t               state;
  logic [1:0]           slot_kind;
  logic signed [W:0]    slot_val;
  logic                 in_acc;
  logic                 out_xfer;
  logic signed [W-1:0]  sol_a, sol_b;
  logic                 sol_err;

  assign in_ready = (state != OUT);
  assign in_acc   = in_valid && in_ready;
  assign out_xfer = out_valid && out_ready;

  sumdiff_solve #(.W(W)) u_solve (
    .kind0 (slot_kind),
    .val0  (slot_val),
    .kind1 (in_sel),
    .val1  (in_c),
    .a     (sol_a),
    .b     (sol_b),
    .err   (sol_err)
  );

  // Capture FSM; clear outranks every other event except rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= EMPTY;
      out_valid <= 1'b0;
      out_a     <= '0;
      out_b     <= '0;
      out_err   <= 1'b0;
      slot_kind <= KIND_A;
      slot_val  <= '0;
    end else if (clear) begin
      state     <= EMPTY;
      out_valid <= 1'b0;
      slot_kind <= KIND_A;
      slot_val  <= '0;
    end else begin
      case (state)
        EMPTY: begin
          if (in_acc) begin
            slot_kind <= in_sel;
            slot_val  <= in_c;
            state     <= ONE;
          end
        end
        ONE: begin
          if (in_acc) begin
            if (in_sel == slot_kind) begin
              slot_val <= in_c;
            end else begin
              out_a     <= sol_a;
              out_b     <= sol_b;
              out_err   <= sol_err;
              out_valid <= 1'b1;
              state     <= OUT;
            end
          end
        end
        OUT: begin
          if (out_xfer) begin
            out_valid <= 1'b0;
            slot_kind <= KIND_A;
            slot_val  <= '0;
            state     <= EMPTY;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_sumdiff_decoder.sv
// Directed bench for sumdiff_decoder: hand-computed operand pairs, backpressure, clear and reset.
module tb_sumdiff_decoder;

  localparam int unsigned W = 8;

  logic                clk = 1'b0;
  logic                rst;
  logic                clear;
  logic                in_valid;
  logic                in_ready;
  logic [1:0]          in_sel;
  logic signed [W:0]   in_c;
  logic                out_valid;
  logic                out_ready;
  logic signed [W-1:0] out_a;
  logic signed [W-1:0] out_b;
  logic                out_err;

  int n_chk  = 0;
  int n_fail = 0;

  sumdiff_decoder #(.W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sel    (in_sel),
    .in_c      (in_c),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_a     (out_a),
    .out_b     (out_b),
    .out_err   (out_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [15:0] obs, input logic signed [15:0] exp_v);
    n_chk++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  // Offer one word for a single cycle; returns 1 ns after the edge.
  task automatic send(input logic [1:0] s, input int c);
    @(negedge clk);
    in_valid = 1'b1;
    in_sel   = s;
    in_c     = 9'(c);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic chk_out(input string tag, input int ea, input int eb, input logic ee);
    chk({tag, ".valid"}, out_valid, 1);
    chk({tag, ".a"}, out_a, 16'(ea));
    chk({tag, ".b"}, out_b, 16'(eb));
    chk({tag, ".err"}, out_err, ee);
    chk({tag, ".in_ready"}, in_ready, 0);
  endtask

  // Pair with out_ready held high: result appears after the second accept, drains on the next edge.
  task automatic pair(input string tag, input logic [1:0] s0, input int c0,
                      input logic [1:0] s1, input int c1,
                      input int ea, input int eb, input logic ee);
    send(s0, c0);
    chk({tag, ".pending"}, out_valid, 0);
    send(s1, c1);
    chk_out(tag, ea, eb, ee);
    @(posedge clk);
    #1;
    chk({tag, ".drained"}, out_valid, 0);
    chk({tag, ".ready_back"}, in_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    clear     = 1'b0;
    in_valid  = 1'b0;
    in_sel    = 2'b00;
    in_c      = '0;
    out_ready = 1'b1;
    #3;
    chk("rst.out_valid", out_valid, 0);
    chk("rst.in_ready", in_ready, 1);
    chk("rst.out_a", out_a, 0);
    chk("rst.out_b", out_b, 0);
    chk("rst.out_err", out_err, 0);
    @(negedge clk);
    rst = 1'b0;

    pair("sumdiff", 2'b10, 5, 2'b11, -9, -2, 7, 1'b0);
    pair("odd", 2'b10, 4, 2'b11, 1, 0, 0, 1'b1);
    pair("ovf_as", 2'b00, 100, 2'b10, -200, 0, 0, 1'b1);
    pair("ovf_b", 2'b01, 200, 2'b00, 1, 0, 0, 1'b1);
    pair("bnd_ab", 2'b00, -128, 2'b01, 127, -128, 127, 1'b0);
    pair("bnd_sd", 2'b10, -256, 2'b11, 0, -128, -128, 1'b0);
    pair("bs", 2'b01, 20, 2'b10, 15, -5, 20, 1'b0);
    pair("bd", 2'b11, 30, 2'b01, -40, -10, -40, 1'b0);

    // Duplicate kind, then backpressure with words offered during the stall.
    out_ready = 1'b0;
    send(2'b00, 3);
    send(2'b00, -4);
    send(2'b11, -10);
    chk_out("dup", -4, 6, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_sel   = 2'b01;
      in_c     = 9'(77);
      chk("stall.in_ready", in_ready, 0);
      chk("stall.valid", out_valid, 1);
      chk("stall.a", out_a, -4);
      chk("stall.b", out_b, 6);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("stall.xfer", out_valid, 0);
    chk("stall.ready_back", in_ready, 1);
    send(2'b00, 10);
    chk("stall.no_leak", out_valid, 0);
    send(2'b11, 4);
    chk_out("after_stall", 10, 6, 1'b0);
    @(posedge clk);
    #1;

    // clear while in ONE discards the captured word.
    send(2'b00, 5);
    @(negedge clk);
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    chk("clr_one.valid", out_valid, 0);
    send(2'b01, 9);
    chk("clr_one.fresh", out_valid, 0);
    send(2'b00, 2);
    chk_out("clr_one", 2, 9, 1'b0);
    @(posedge clk);
    #1;

    // clear coinciding with a completing accept produces no output.
    send(2'b00, 3);
    @(negedge clk);
    in_valid = 1'b1;
    in_sel   = 2'b01;
    in_c     = 9'(4);
    clear    = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    clear    = 1'b0;
    chk("clr_acc.valid", out_valid, 0);
    send(2'b01, 5);
    chk("clr_acc.fresh", out_valid, 0);
    send(2'b00, 7);
    chk_out("clr_acc", 7, 5, 1'b0);
    @(posedge clk);
    #1;

    // clear together with an output transfer.
    out_ready = 1'b0;
    send(2'b10, 6);
    send(2'b11, 2);
    chk_out("clr_xfer.pre", 4, 2, 1'b0);
    @(negedge clk);
    clear     = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    chk("clr_xfer.valid", out_valid, 0);
    chk("clr_xfer.in_ready", in_ready, 1);
    send(2'b00, 1);
    chk("clr_xfer.fresh", out_valid, 0);
    send(2'b01, 1);
    chk_out("clr_xfer.next", 1, 1, 1'b0);
    @(posedge clk);
    #1;

    // Asynchronous reset in ONE, between edges.
    send(2'b00, 8);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_one.valid", out_valid, 0);
    chk("rst_one.in_ready", in_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    send(2'b01, 3);
    chk("rst_one.fresh", out_valid, 0);
    send(2'b00, 4);
    chk_out("rst_one.next", 4, 3, 1'b0);
    @(posedge clk);
    #1;

    // Asynchronous reset while a result is held.
    out_ready = 1'b0;
    send(2'b00, 11);
    send(2'b01, 12);
    chk_out("rst_out.pre", 11, 12, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_out.valid", out_valid, 0);
    chk("rst_out.in_ready", in_ready, 1);
    chk("rst_out.a", out_a, 0);
    chk("rst_out.b", out_b, 0);
    @(negedge clk);
    rst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
